// File: rtl/alu_pkg.sv
// Shared types for the ALU issue queue: request struct, select width, illegal-select helper.
package alu_pkg;
  localparam int N_DEF   = 32;
  localparam int SEL_W   = 4;
  localparam int NUM_OPS = 8;

  typedef struct packed {
    logic [N_DEF-1:0] A;
    logic [N_DEF-1:0] B;
    logic [SEL_W-1:0] S;
  } alu_req_t;

  // Only the low NUM_OPS codes are defined; the top select bit marks an illegal op.
  function automatic logic is_illegal_sel(input logic [SEL_W-1:0] s);
    return s[SEL_W-1];
  endfunction
endpackage

// File: rtl/alu_issue_queue_if.sv
// Request/result handshake bundle for alu_issue_queue; master drives requests, slave is the queue.
interface alu_issue_queue_if #(
  parameter int n     = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic         in_valid;
  logic         in_ready;
  logic [n-1:0] in_A;
  logic [n-1:0] in_B;
  logic [3:0]   in_S;
  logic         out_valid;
  logic         out_ready;
  logic [n-1:0] out_Z;
  logic [3:0]   out_S;
  logic         out_zero;
  logic         out_neg;
  logic         out_err;
  logic [CW-1:0] count;

  modport master (
    output in_valid, in_A, in_B, in_S, out_ready,
    input  in_ready, out_valid, out_Z, out_S, out_zero, out_neg, out_err, count
  );

  modport slave (
    input  in_valid, in_A, in_B, in_S, out_ready,
    output in_ready, out_valid, out_Z, out_S, out_zero, out_neg, out_err, count
  );
endinterface

// File: rtl/alu.sv
// Combinational ALU: 8 ops on S[2:0]; S[3] set yields zero.
module alu #(
  parameter int n = 32
) (
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  input  logic [3:0]   S,
  output logic [n-1:0] Z
);
  localparam int SH_W = $clog2(n);

  always_comb begin
    Z = '0;
    if (!S[3]) begin
      case (S[2:0])
        3'd0: Z = A + B;
        3'd1: Z = A - B;
        3'd2: Z = A & B;
        3'd3: Z = A | B;
        3'd4: Z = A ^ B;
        3'd5: Z = A << B[SH_W-1:0];
        3'd6: Z = A >> B[SH_W-1:0];
        3'd7: Z = {{(n-1){1'b0}}, ($signed(A) < $signed(B))};
      endcase
    end
  end
endmodule

// File: rtl/alu_issue_queue_op_fifo.sv
// Request FIFO: power-of-two depth, natural pointer wrap, separate occupancy counter.
module alu_op_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push_i,
  input  alu_req_t wdata_i,
  input  logic     pop_i,
  output alu_req_t rdata_o,
  output logic     full_o,
  output logic     empty_o,
  output logic [CW-1:0] count_o
);
  alu_req_t        mem_q [DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [CW-1:0]   cnt_q;

  // Storage needs no reset; occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_q];
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
endmodule

// File: rtl/alu_issue_queue.sv
// Issue queue in front of the combinational ALU: FIFO of requests, head drives the ALU, registered result.
module alu_issue_queue
  import alu_pkg::*;
#(
  parameter int n     = 32,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  alu_issue_queue_if.slave io
);
  alu_req_t     wreq, head;
  logic         full, empty, push, pop, illegal;
  logic [n-1:0] z;

  logic         out_valid_q, out_valid_d;
  logic [n-1:0] out_z_q, out_z_d;
  logic [3:0]   out_s_q, out_s_d;
  logic         out_zero_q, out_zero_d;
  logic         out_neg_q, out_neg_d;
  logic         out_err_q, out_err_d;

  // Full blocks pushes even when a pop frees a slot this cycle, keeping in_ready purely registered.
  assign io.in_ready = !full;
  assign push        = io.in_valid && !full;
  assign pop         = !empty && (!out_valid_q || io.out_ready);
  assign wreq        = '{A: io.in_A, B: io.in_B, S: io.in_S};

  alu_op_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (wreq),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (io.count)
  );

  alu #(.n(n)) u_alu (
    .A (head.A),
    .B (head.B),
    .S (head.S),
    .Z (z)
  );

  assign illegal = is_illegal_sel(head.S);

  always_comb begin
    out_valid_d = out_valid_q;
    out_z_d     = out_z_q;
    out_s_d     = out_s_q;
    out_zero_d  = out_zero_q;
    out_neg_d   = out_neg_q;
    out_err_d   = out_err_q;
    if (pop) begin
      out_valid_d = 1'b1;
      out_z_d     = illegal ? '0 : z;
      out_s_d     = head.S;
      out_zero_d  = (out_z_d == '0);
      out_neg_d   = out_z_d[n-1];
      out_err_d   = illegal;
    end else if (io.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_z_q     <= '0;
      out_s_q     <= '0;
      out_zero_q  <= 1'b0;
      out_neg_q   <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_z_q     <= out_z_d;
      out_s_q     <= out_s_d;
      out_zero_q  <= out_zero_d;
      out_neg_q   <= out_neg_d;
      out_err_q   <= out_err_d;
    end
  end

  assign io.out_valid = out_valid_q;
  assign io.out_Z     = out_z_q;
  assign io.out_S     = out_s_q;
  assign io.out_zero  = out_zero_q;
  assign io.out_neg   = out_neg_q;
  assign io.out_err   = out_err_q;
endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue: reset, single op, fill/drain, illegal select, wrap stream, mid-stream reset.
module tb_alu_issue_queue;
  logic clk = 1'b0;
  logic rst;
  int   ncmp = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  alu_issue_queue_if #(.n(32), .DEPTH(4)) bus ();

  alu_issue_queue #(.n(32), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
    if (s[3]) return 32'd0;
    unique case (s[2:0])
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << b[4:0];
      3'd6: return a >> b[4:0];
      default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
    bus.in_valid = v;
    bus.in_A     = a;
    bus.in_B     = b;
    bus.in_S     = s;
  endtask

  initial begin
    logic [31:0] expq[$];
    int          got;

    // Reset with a request pending: nothing may be recorded.
    rst = 1'b1;
    bus.out_ready = 1'b0;
    drive(1'b1, 32'd7, 32'd7, 4'd0);
    step();
    step();
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_Z", bus.out_Z, 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 4'd0);
    step();
    check("rst_no_push", 32'(bus.count), 32'd0);

    // Single request 5+3.
    bus.out_ready = 1'b1;
    drive(1'b1, 32'd5, 32'd3, 4'd0);
    step();
    drive(1'b0, 32'd0, 32'd0, 4'd0);
    check("single_count_k", 32'(bus.count), 32'd1);
    check("single_no_bypass", 32'(bus.out_valid), 32'd0);
    step();
    check("single_valid", 32'(bus.out_valid), 32'd1);
    check("single_Z", bus.out_Z, 32'd8);
    check("single_S", 32'(bus.out_S), 32'd0);
    check("single_err", 32'(bus.out_err), 32'd0);
    step();
    check("single_drained", 32'(bus.out_valid), 32'd0);

    // Fill with out_ready low: i0 to result reg, i1..i4 in FIFO.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'(i), 32'(2*i), 4'(i));
      step();
    end
    drive(1'b1, 32'd5, 32'd10, 4'd5);
    check("fill_count", 32'(bus.count), 32'd4);
    check("fill_in_ready", 32'(bus.in_ready), 32'd0);
    check("fill_hold_valid", 32'(bus.out_valid), 32'd1);
    check("fill_hold_Z", bus.out_Z, 32'd0);
    step();
    check("fill_still_hold", bus.out_Z, 32'd0);
    check("fill_still_full", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    step();
    check("drain1_Z", bus.out_Z, 32'hFFFF_FFFF);
    check("drain1_neg", 32'(bus.out_neg), 32'd1);
    check("drain1_count", 32'(bus.count), 32'd3);
    check("drain1_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    drive(1'b0, 32'd0, 32'd0, 4'd0);
    check("drain2_Z", bus.out_Z, 32'd0);
    check("drain2_zero", 32'(bus.out_zero), 32'd1);
    check("drain2_count", 32'(bus.count), 32'd3);
    step();
    check("drain3_Z", bus.out_Z, 32'd7);
    check("drain3_count", 32'(bus.count), 32'd2);
    step();
    check("drain4_Z", bus.out_Z, 32'd12);
    step();
    check("drain5_Z", bus.out_Z, 32'h0000_1400);
    check("drain5_S", 32'(bus.out_S), 32'd5);
    check("drain5_count", 32'(bus.count), 32'd0);
    step();
    check("drain_empty", 32'(bus.out_valid), 32'd0);

    // Illegal select, then a legal op right behind it.
    drive(1'b1, 32'd1, 32'd1, 4'b1010);
    step();
    drive(1'b1, 32'd9, 32'd4, 4'd1);
    step();
    drive(1'b0, 32'd0, 32'd0, 4'd0);
    check("illegal_err", 32'(bus.out_err), 32'd1);
    check("illegal_Z", bus.out_Z, 32'd0);
    check("illegal_zero", 32'(bus.out_zero), 32'd1);
    check("illegal_S", 32'(bus.out_S), 32'hA);
    step();
    check("post_illegal_Z", bus.out_Z, 32'd5);
    check("post_illegal_err", 32'(bus.out_err), 32'd0);
    check("post_illegal_zero", 32'(bus.out_zero), 32'd0);
    step();

    // 20 back-to-back requests: pointers wrap repeatedly, one result per cycle.
    bus.out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 24; c++) begin
      if (c < 20) begin
        drive(1'b1, 32'(3*c + 1), 32'(c), 4'(c % 8));
        expq.push_back(ref_alu(32'(3*c + 1), 32'(c), 4'(c % 8)));
      end else begin
        drive(1'b0, 32'd0, 32'd0, 4'd0);
      end
      step();
      check("stream_count_le1", 32'(bus.count <= 1), 32'd1);
      if (bus.out_valid && expq.size() > 0) begin
        check($sformatf("stream_Z%0d", got), bus.out_Z, expq.pop_front());
        got++;
      end
    end
    check("stream_total", 32'(got), 32'd20);

    // Mid-stream reset with queued entries and a held result.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(100 + i), 32'd0, 4'd0);
      step();
    end
    drive(1'b0, 32'd0, 32'd0, 4'd0);
    check("pre_rst_count", 32'(bus.count), 32'd3);
    check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_count", 32'(bus.count), 32'd0);
    check("mid_rst_Z", bus.out_Z, 32'd0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("mid_rst_no_ghost", 32'(bus.out_valid), 32'd0);
    end
    drive(1'b1, 32'd42, 32'd1, 4'd0);
    step();
    drive(1'b0, 32'd0, 32'd0, 4'd0);
    step();
    check("post_rst_valid", 32'(bus.out_valid), 32'd1);
    check("post_rst_Z", bus.out_Z, 32'd43);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
